// File: rtl/wb_arb_decode.sv
// wb_arb_decode: two-master round-robin Wishbone arbiter with N-slave address decode, decode-error and timeout err generation
module wb_arb_decode #(
  parameter int NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*32-1:0] SLV_BASE = {32'h7000_2000, 32'h7000_1000, 32'h7000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*32-1:0] SLV_MASK = {32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_C000},
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              m0_adr_i,
  input  logic [31:0]              m1_adr_i,
  input  logic [31:0]              m0_dat_i,
  input  logic [31:0]              m1_dat_i,
  input  logic [3:0]               m0_sel_i,
  input  logic [3:0]               m1_sel_i,
  input  logic                     m0_we_i,
  input  logic                     m1_we_i,
  input  logic                     m0_cyc_i,
  input  logic                     m1_cyc_i,
  input  logic                     m0_stb_i,
  input  logic                     m1_stb_i,
  output logic [31:0]              m0_dat_o,
  output logic [31:0]              m1_dat_o,
  output logic                     m0_ack_o,
  output logic                     m1_ack_o,
  output logic                     m0_err_o,
  output logic                     m1_err_o,
  output logic [31:0]              s_adr_o,
  output logic [31:0]              s_dat_o,
  output logic [3:0]               s_sel_o,
  output logic                     s_we_o,
  output logic [NUM_SLAVES-1:0]    s_cyc_o,
  output logic [NUM_SLAVES-1:0]    s_stb_o,
  input  logic [NUM_SLAVES*32-1:0] s_dat_i,
  input  logic [NUM_SLAVES-1:0]    s_ack_i,
  input  logic [NUM_SLAVES-1:0]    s_err_i,
  output logic                     bus_err_o,
  output logic                     err_type_o,
  output logic [31:0]              err_adr_o,
  output logic [1:0]               owner_o
);
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;
  state_t state, state_nxt;
  logic [1:0] owner, owner_nxt;
  logic last_m1, last_m1_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic bus_err_nxt, err_type_nxt;
  logic [31:0] err_adr_nxt;
  logic sel0, sel1, busy, in_err, r0, r1;
  logic [31:0] o_adr, o_dat, r_dat;
  logic [3:0] o_sel;
  logic o_we, o_cyc, o_stb, any_hit, s_ack, s_err, r_err, wait_cyc, tmo;
  logic [NUM_SLAVES-1:0] hit_vec, hit_oh;
  assign sel0 = owner == 2'b01;
  assign sel1 = owner == 2'b10;
  assign busy = state == BUSY;
  assign in_err = state == ERR;
  assign r0 = m0_cyc_i & m0_stb_i;
  assign r1 = m1_cyc_i & m1_stb_i;
  assign o_adr = sel0 ? m0_adr_i : sel1 ? m1_adr_i : '0;
  assign o_dat = sel0 ? m0_dat_i : sel1 ? m1_dat_i : '0;
  assign o_sel = sel0 ? m0_sel_i : sel1 ? m1_sel_i : '0;
  assign o_we  = sel0 ? m0_we_i  : sel1 & m1_we_i;
  assign o_cyc = sel0 ? m0_cyc_i : sel1 & m1_cyc_i;
  assign o_stb = sel0 ? m0_stb_i : sel1 & m1_stb_i;
  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_dec
    assign hit_vec[g] = (o_adr & SLV_MASK[32*g +: 32]) == SLV_BASE[32*g +: 32];
  end
  // isolate the lowest set bit so overlapping windows resolve to the lowest slave index
  assign hit_oh = hit_vec & (~hit_vec + NUM_SLAVES'(1));
  assign any_hit = |hit_vec;
  always_comb begin
    r_dat = '0;
    for (int i = 0; i < NUM_SLAVES; i++) r_dat = r_dat | (s_dat_i[32*i +: 32] & {32{hit_oh[i]}});
  end
  assign s_ack = busy & |(s_ack_i & hit_oh);
  assign s_err = busy & |(s_err_i & hit_oh);
  assign r_err = s_err | in_err;
  assign wait_cyc = busy & o_cyc & o_stb & any_hit & ~s_ack & ~s_err;
  assign tmo = TIMEOUT_CYCLES != 0 && wait_cyc && cnt == CW'(TIMEOUT_CYCLES - 1);
  assign s_adr_o = o_adr;
  assign s_dat_o = o_dat;
  assign s_sel_o = o_sel;
  assign s_we_o = o_we;
  assign s_cyc_o = {NUM_SLAVES{busy & o_cyc}} & hit_oh;
  assign s_stb_o = {NUM_SLAVES{busy & o_stb}} & hit_oh;
  assign m0_ack_o = sel0 & s_ack;
  assign m1_ack_o = sel1 & s_ack;
  assign m0_err_o = sel0 & r_err;
  assign m1_err_o = sel1 & r_err;
  assign m0_dat_o = {32{sel0 & busy}} & r_dat;
  assign m1_dat_o = {32{sel1 & busy}} & r_dat;
  assign owner_o = owner;
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_m1_nxt = last_m1;
    bus_err_nxt = 1'b0;
    err_type_nxt = err_type_o;
    err_adr_nxt = err_adr_o;
    cnt_nxt = TIMEOUT_CYCLES != 0 && wait_cyc ? (cnt == CW'(TIMEOUT_CYCLES) ? cnt : cnt + 1'b1) : '0;
    case (state)
      IDLE: if (r0 | r1) begin
        state_nxt = BUSY;
        owner_nxt = r0 && (!r1 || last_m1) ? 2'b01 : 2'b10;
      end
      BUSY: if (!o_cyc) begin
        state_nxt = IDLE;
        owner_nxt = '0;
        last_m1_nxt = sel1;
      end else if ((o_stb && !any_hit) || tmo) begin
        state_nxt = ERR;
        bus_err_nxt = 1'b1;
        err_type_nxt = any_hit;
        err_adr_nxt = o_adr;
      end
      ERR: if (!o_cyc) begin
        state_nxt = IDLE;
        owner_nxt = '0;
        last_m1_nxt = sel1;
      end else state_nxt = BUSY;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      owner <= '0;
      last_m1 <= 1'b1;
      cnt <= '0;
      bus_err_o <= 1'b0;
      err_type_o <= 1'b0;
      err_adr_o <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      last_m1 <= last_m1_nxt;
      cnt <= cnt_nxt;
      bus_err_o <= bus_err_nxt;
      err_type_o <= err_type_nxt;
      err_adr_o <= err_adr_nxt;
    end
  end
endmodule
